multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM for a multicycle RISC-V style core (lw, sw, R-type,
// I-type ALU, beq, jal). An undecodable opcode parks the FSM in TRAP until
// reset.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-low reset
//   op/funct3/funct7b5  fields of the registered instruction
//   Zero          ALU zero flag (branch resolution)
//   mem_ready     memory completes the current access this cycle
//   mem_req       memory access requested
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc            datapath mux selects
//   ALUControl    000 add, 001 sub, 010 and, 011 or, 101 slt
//   instr_retired one-cycle pulse in the final cycle of each instruction
//   halted        high while parked in TRAP
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_retired,
    output logic       halted
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state_q, state_d;
    logic [1:0] aluop;
    logic       pcw_raw, irw_raw, rw_raw, mw_raw, ret_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Per-state outputs; anything not assigned in a state stays 0
    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        aluop     = ALUOP_ADD;
        pcw_raw   = 1'b0;
        irw_raw   = 1'b0;
        rw_raw    = 1'b0;
        mw_raw    = 1'b0;
        ret_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw_raw   = mem_ready;
                pcw_raw   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rw_raw    = 1'b1;
                ret_raw   = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                mw_raw  = 1'b1;
                // store retires in the cycle memory accepts it
                ret_raw = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                rw_raw  = 1'b1;
                ret_raw = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_SUB;
                pcw_raw = Zero;
                ret_raw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // While reset is held the state already reads FETCH, but FETCH drives
    // IRWrite/PCWrite from mem_ready; gate enables so nothing commits.
    assign PCWrite       = rst & pcw_raw;
    assign IRWrite       = rst & irw_raw;
    assign RegWrite      = rst & rw_raw;
    assign MemWrite      = rst & mw_raw;
    assign instr_retired = rst & ret_raw;
    assign halted        = rst & (state_q == S_TRAP);

    // ALU decode
    always_comb begin
        ALUControl = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:     ALUControl = ALU_ADD;
        endcase
    end

    // Immediate format from opcode; TRAP keeps every output other than
    // halted at 0.
    always_comb begin
        ImmSrc = 2'b00;
        if (state_q != S_TRAP) begin
            case (op)
                OP_SW:   ImmSrc = 2'b01;
                OP_BEQ:  ImmSrc = 2'b10;
                OP_JAL:  ImmSrc = 2'b11;
                default: ImmSrc = 2'b00;
            endcase
        end
    end

endmodule
